// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic matrix multiplier.
package systolic_pkg;

  localparam int unsigned NDefault     = 3;
  localparam int unsigned DataWDefault = 8;
  localparam int unsigned AccWDefault  = 2 * DataWDefault + NDefault - 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a right and b down after one cycle and
// accumulates a*b, extended to the accumulator width as signed or unsigned.
module systolic_pe import systolic_pkg::*; #(
  parameter int unsigned DataW = DataWDefault,
  parameter int unsigned AccW  = AccWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             signed_i,
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  output logic [DataW-1:0] a_o,
  output logic [DataW-1:0] b_o,
  output logic [AccW-1:0]  acc_o
);

  logic [DataW-1:0] a_q, a_d, b_q, b_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  a_ext, b_ext, prod;

  always_comb begin
    a_ext = signed_i ? {{(AccW-DataW){a_i[DataW-1]}}, a_i} : {{(AccW-DataW){1'b0}}, a_i};
    b_ext = signed_i ? {{(AccW-DataW){b_i[DataW-1]}}, b_i} : {{(AccW-DataW){1'b0}}, b_i};
    // Truncated product of the extended operands is exact modulo 2^AccW.
    prod  = a_ext * b_ext;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul.sv
// NxN output-stationary systolic array computing C = A*B from N column/row
// beats, with internal input skewing and a registered result.
module systolic_matmul import systolic_pkg::*; #(
  parameter int unsigned N      = NDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ACC_W  = 2 * DATA_W + N - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_W-1:0]    a_col,
  input  logic [N*DATA_W-1:0]    b_row,
  output logic                   busy,
  output logic                   out_valid,
  output logic [N*N*ACC_W-1:0]   out_arr
);

  localparam int unsigned CntW = $clog2(2 * N);
  localparam logic [CntW-1:0] LastBeat  = CntW'(N - 1);
  localparam logic [CntW-1:0] LastDrain = CntW'(2 * N - 2);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic [N*N*ACC_W-1:0]   out_q, out_d;
  logic [N*N*ACC_W-1:0]   acc_flat;
  logic                   clr, en, beat_ok, drain_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    clr        = 1'b0;
    en         = 1'b0;
    in_ready   = 1'b0;
    drain_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr     = 1'b1;
          mode_d  = signed_mode;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        en       = 1'b1;
        if (in_valid) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        en = 1'b1;
        if (cnt_q == LastDrain) begin
          drain_last = 1'b1;
          cnt_d      = '0;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    out_d = out_q;
    if (clr) begin
      out_d = '0;
    end else if (drain_last) begin
      out_d = acc_flat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign beat_ok   = (state_q == StLoad) && in_valid;
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_arr   = out_q;

  logic [DATA_W-1:0] a_sk [N];
  logic [DATA_W-1:0] b_sk [N];

  // Lane l is delayed by l cycles; stalls and drain inject zeros.
  for (genvar l = 0; l < N; l++) begin : g_skew
    logic [DATA_W-1:0] a_lane, b_lane;
    assign a_lane = beat_ok ? a_col[l*DATA_W +: DATA_W] : '0;
    assign b_lane = beat_ok ? b_row[l*DATA_W +: DATA_W] : '0;
    if (l == 0) begin : g_direct
      assign a_sk[l] = a_lane;
      assign b_sk[l] = b_lane;
    end else begin : g_dly
      logic [DATA_W-1:0] a_sr_q [l];
      logic [DATA_W-1:0] a_sr_d [l];
      logic [DATA_W-1:0] b_sr_q [l];
      logic [DATA_W-1:0] b_sr_d [l];
      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (clr) begin
          a_sr_d = '{default: '0};
          b_sr_d = '{default: '0};
        end else if (en) begin
          a_sr_d[0] = a_lane;
          b_sr_d[0] = b_lane;
          for (int s = 1; s < l; s++) begin
            a_sr_d[s] = a_sr_q[s-1];
            b_sr_d[s] = b_sr_q[s-1];
          end
        end
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_sr_q <= '{default: '0};
          b_sr_q <= '{default: '0};
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end
      assign a_sk[l] = a_sr_q[l-1];
      assign b_sk[l] = b_sr_q[l-1];
    end
  end

  logic [DATA_W-1:0] a_fwd [N][N];
  logic [DATA_W-1:0] b_fwd [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] pe_a, pe_b;
      if (j == 0) begin : g_a_edge
        assign pe_a = a_sk[i];
      end else begin : g_a_int
        assign pe_a = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign pe_b = b_sk[j];
      end else begin : g_b_int
        assign pe_b = b_fwd[i-1][j];
      end
      systolic_pe #(
        .DataW(DATA_W),
        .AccW (ACC_W)
      ) u_pe (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (clr),
        .en_i    (en),
        .signed_i(mode_q),
        .a_i     (pe_a),
        .b_i     (pe_b),
        .a_o     (a_fwd[i][j]),
        .b_o     (b_fwd[i][j]),
        .acc_o   (acc_flat[(i*N+j)*ACC_W +: ACC_W])
      );
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Scoreboard bench for systolic_matmul (N=3, 8-bit operands, 18-bit results).
module tb_systolic_matmul;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int OW = N * N * AW;

  typedef int mat_t [3][3];
  typedef struct {
    logic [OW-1:0] c;
    int            first_lat;
  } exp_t;

  logic            clk, reset, start, signed_mode, in_valid;
  logic            in_ready, busy, out_valid;
  logic [N*DW-1:0] a_col, b_row;
  logic [OW-1:0]   out_arr;

  systolic_matmul #(
    .N     (N),
    .DATA_W(DW),
    .ACC_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_col      (a_col),
    .b_row      (b_row),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_arr    (out_arr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   first_edge = 0;
  int   last_edge = 0;
  bit   prev_ov = 1'b0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [OW-1:0] pack_c(input mat_t c);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*AW +: AW] = AW'(c[i][j]);
    return r;
  endfunction

  // Monitor: pops and compares whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!reset) begin
      prev_ov = 1'b0;
    end else if (out_valid) begin
      exp_t e;
      check("single_pulse", OW'(prev_ov), OW'(0));
      check("in_ready_done", OW'(in_ready), OW'(0));
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 want no result pending");
      end else begin
        e = sb_q.pop_front();
        check("result", out_arr, e.c);
        check("latency_last_beat", OW'(cyc - last_edge), OW'(2 * N - 1));
        if (e.first_lat >= 0) check("latency_first_beat", OW'(cyc - first_edge), OW'(e.first_lat));
      end
      prev_ov = 1'b1;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic run_op(input mat_t a, input mat_t b, input bit smode, input int gap,
                        input mat_t c, input int first_lat, input bit poke, input bit push);
    exp_t e;
    @(negedge clk);
    start       = 1'b1;
    signed_mode = smode;
    if (push) begin
      e.c         = pack_c(c);
      e.first_lat = first_lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start       = 1'b0;
    signed_mode = ~smode;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          a_col    = N*DW'($urandom);
          b_row    = N*DW'($urandom);
          @(negedge clk);
        end
      end
      for (int l = 0; l < N; l++) begin
        a_col[l*DW +: DW] = DW'(a[l][k]);
        b_row[l*DW +: DW] = DW'(b[k][l]);
      end
      in_valid = 1'b1;
      start    = poke;
      check("in_ready_load", OW'(in_ready), OW'(1));
      if (k == 0) first_edge = cyc + 1;
      last_edge = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    start    = poke;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("completion_timeout", OW'(n < 60), OW'(1));
  endtask

  mat_t ma, mb, mc1, mid, mff, m02, mneg6, m1530;
  logic [OW-1:0] held;

  initial begin
    ma  = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb  = '{'{2, 1, 3}, '{4, 5, 7}, '{6, 9, 8}};
    mc1 = '{'{28, 38, 41}, '{64, 83, 95}, '{100, 128, 149}};
    mid = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mff = '{default: '{default: 255}};
    m02 = '{default: '{default: 2}};
    mneg6 = '{default: '{default: 'h3FFFA}};
    m1530 = '{default: '{default: 1530}};

    reset       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    a_col       = '0;
    b_row       = '0;
    #1;
    check("reset_busy", OW'(busy), OW'(0));
    check("reset_in_ready", OW'(in_ready), OW'(0));
    check("reset_out_valid", OW'(out_valid), OW'(0));
    check("reset_out_arr", out_arr, OW'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_op(ma, mb, 1'b0, 0, mc1, 7, 1'b0, 1'b1);
    wait_idle();
    check("idle_in_ready", OW'(in_ready), OW'(0));

    run_op(ma, mb, 1'b0, 2, mc1, 11, 1'b0, 1'b1);
    wait_idle();

    run_op(mff, m02, 1'b1, 0, mneg6, 7, 1'b0, 1'b1);
    wait_idle();
    run_op(mff, m02, 1'b0, 0, m1530, 7, 1'b0, 1'b1);
    wait_idle();

    run_op(ma, mb, 1'b0, 0, mc1, 7, 1'b1, 1'b1);
    wait_idle();

    // Abort mid-drain: no result is expected from this operation.
    run_op(ma, mb, 1'b0, 0, mc1, 7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", OW'(busy), OW'(0));
    check("abort_out_arr", out_arr, OW'(0));
    check("abort_out_valid", OW'(out_valid), OW'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    run_op(ma, mb, 1'b0, 0, mc1, 7, 1'b0, 1'b1);
    wait_idle();

    run_op(mid, mb, 1'b0, 0, mb, 7, 1'b0, 1'b1);
    wait_idle();
    held = pack_c(mb);
    begin
      int bad;
      bad = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (out_arr !== held) bad++;
      end
      check("hold_cycles_changed", OW'(bad), OW'(0));
    end
    check("hold_value", out_arr, held);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
